// File: rtl/switch_debounce_ctrl.sv
// switch_debounce_ctrl
//   Avalon-MM slave for the slide-switch port. Raw switch levels are
//   synchronized, debounced per bit on a prescaled sample tick, and
//   debounced transitions are captured in a W1C edge register that can
//   raise a maskable level interrupt.
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   address        register select: 0 DATA, 1 MASK, 2 EDGE, 3 CTRL
//   chipselect     slave select
//   write_n        active-low write strobe, qualified by chipselect
//   writedata      write data
//   readdata       registered read data (1-cycle latency, 0 when idle)
//   in_port        raw asynchronous switch levels
//   irq            registered interrupt, |(edge & mask)
module switch_debounce_ctrl #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DIV_DEFAULT    = 50000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [15:0] DIV_RST   = 16'(DIV_DEFAULT);
  localparam logic [3:0]  STAB_LAST = 4'(STABLE_SAMPLES - 1);

  logic [WIDTH-1:0]      sync1_q, sync2_q;
  logic [WIDTH-1:0]      deb_q, deb_d;
  logic [WIDTH-1:0]      edge_q, edge_d;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [WIDTH-1:0][3:0] stab_q, stab_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           div_q, div_d;
  logic [1:0]            mode_q, mode_d;
  logic                  en_q, en_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;

  logic                  wr_en;
  logic [15:0]           div_m1;
  logic                  tick;
  logic [WIDTH-1:0]      rise, fall, qual;
  logic                  unused_wdata;

  assign readdata     = rdata_q;
  assign irq          = irq_q;
  assign unused_wdata = ^{writedata[31:25], writedata[23:18]};

  always_comb begin
    wr_en  = chipselect && !write_n;
    // divider 0 behaves like 1: tick every cycle
    div_m1 = (div_q == '0) ? '0 : div_q - 16'd1;
    tick   = en_q && (cnt_q >= div_m1);

    mask_d = mask_q;
    div_d  = div_q;
    mode_d = mode_q;
    en_d   = en_q;
    if (wr_en && address == 2'd1) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd3) begin
      div_d  = writedata[15:0];
      mode_d = writedata[17:16];
      en_d   = writedata[24];
    end

    if ((wr_en && address == 2'd3) || !en_q || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    deb_d  = deb_q;
    stab_d = stab_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        stab_d[i] = '0;
      end else if (tick) begin
        if (stab_q[i] == STAB_LAST) begin
          deb_d[i]  = sync2_q[i];
          stab_d[i] = '0;
        end else begin
          stab_d[i] = stab_q[i] + 4'd1;
        end
      end
    end

    rise = deb_d & ~deb_q;
    fall = deb_q & ~deb_d;
    case (mode_q)
      2'b00:   qual = rise;
      2'b01:   qual = fall;
      default: qual = rise | fall;
    endcase

    // clear applied first so a same-cycle capture wins
    edge_d = edge_q;
    if (wr_en && address == 2'd2) begin
      edge_d = edge_q & ~writedata[WIDTH-1:0];
    end
    edge_d = edge_d | qual;

    irq_d = |(edge_q & mask_q);

    rdata_d = '0;
    if (chipselect) begin
      case (address)
        2'd0:    rdata_d[WIDTH-1:0] = deb_q;
        2'd1:    rdata_d[WIDTH-1:0] = mask_q;
        2'd2:    rdata_d[WIDTH-1:0] = edge_q;
        default: rdata_d = {7'b0, en_q, 6'b0, mode_q, div_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
      stab_q  <= '0;
      cnt_q   <= '0;
      div_q   <= DIV_RST;
      mode_q  <= 2'b00;
      en_q    <= 1'b1;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      stab_q  <= stab_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
module tb_switch_debounce_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  switch_debounce_ctrl #(
    .WIDTH(8),
    .DIV_DEFAULT(50000),
    .STABLE_SAMPLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );

  // Behavioural reference: sample history, integer tick counter,
  // per-switch integer stability counts.
  logic [7:0] m_s1, m_s2, m_deb, m_edge, m_mask;
  int         m_stab[8];
  int         m_cnt, m_div, m_mode;
  bit         m_en;
  logic [31:0] m_rd;
  bit         m_irq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_edge = 0; m_mask = 0;
    for (int i = 0; i < 8; i++) m_stab[i] = 0;
    m_cnt = 0; m_div = 50000; m_mode = 0; m_en = 1;
    m_rd = 0; m_irq = 0;
  endtask

  // One clock: predict from pre-edge inputs, advance, compare.
  task automatic cycle();
    bit wr, tick;
    int effdiv, ncnt, ndiv, nmode;
    bit nen;
    int ns[8];
    logic [7:0] nd, qual, ne, nmask, nin;
    logic [31:0] nrd;
    bit nirq;
    wr     = chipselect && !write_n;
    nin    = in_port;
    effdiv = (m_div == 0) ? 1 : m_div;
    tick   = m_en && (m_cnt >= effdiv - 1);
    ncnt   = (wr && address == 3) ? 0 : ((!m_en || tick) ? 0 : m_cnt + 1);
    nd = m_deb;
    for (int i = 0; i < 8; i++) begin
      ns[i] = m_stab[i];
      if (m_s2[i] == m_deb[i]) ns[i] = 0;
      else if (tick) begin
        ns[i] = ns[i] + 1;
        if (ns[i] == 4) begin
          nd[i] = m_s2[i];
          ns[i] = 0;
        end
      end
    end
    case (m_mode)
      0:       qual = nd & ~m_deb;
      1:       qual = ~nd & m_deb;
      default: qual = nd ^ m_deb;
    endcase
    ne = m_edge;
    if (wr && address == 2) ne = ne & ~writedata[7:0];
    ne = ne | qual;
    nirq = |(m_edge & m_mask);
    nrd = 0;
    if (chipselect) begin
      case (address)
        0: nrd = 32'(m_deb);
        1: nrd = 32'(m_mask);
        2: nrd = 32'(m_edge);
        default: nrd = m_div + m_mode * 65536 + (m_en ? 32'h0100_0000 : 0);
      endcase
    end
    nmask = m_mask; ndiv = m_div; nmode = m_mode; nen = m_en;
    if (wr && address == 1) nmask = writedata[7:0];
    if (wr && address == 3) begin
      ndiv  = int'(writedata % 65536);
      nmode = int'((writedata / 65536) % 4);
      nen   = writedata[24];
    end
    @(posedge clk);
    #1;
    m_s2 = m_s1; m_s1 = nin;
    m_deb = nd; m_edge = ne; m_mask = nmask;
    for (int i = 0; i < 8; i++) m_stab[i] = ns[i];
    m_cnt = ncnt; m_div = ndiv; m_mode = nmode; m_en = nen;
    m_rd = nrd; m_irq = nirq;
    check("model readdata", readdata, m_rd);
    check("model irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    chipselect = 0; write_n = 1;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1; write_n = 0; writedata = d;
    cycle();
    chipselect = 0; write_n = 1; writedata = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1; write_n = 1;
    cycle();
    d = readdata;
    chipselect = 0;
  endtask

  task automatic do_reset();
    chipselect = 0; write_n = 1; address = 0; writedata = 0; in_port = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  typedef struct {
    logic [1:0]  addr;
    bit          cs;
    bit          wn;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_irq;
  } vec_t;
  vec_t vecs[$];

  function automatic void addv(logic [1:0] a, bit cs, bit wn, logic [31:0] wd,
                               logic [31:0] er, bit ei);
    vec_t v;
    v.addr = a; v.cs = cs; v.wn = wn; v.wd = wd; v.exp_rd = er; v.exp_irq = ei;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] d;
    bit seen;

    addv(3, 1, 1, 0,            32'h0100_C350, 0);
    addv(0, 1, 1, 0,            0,             0);
    addv(1, 1, 1, 0,            0,             0);
    addv(2, 1, 1, 0,            0,             0);
    addv(1, 1, 0, 32'hFFFF_FFA5, 0,            0);
    addv(1, 1, 1, 0,            32'h0000_00A5, 0);
    addv(3, 1, 0, 32'hFFFF_FFFF, 32'h0100_C350, 0);
    addv(3, 1, 1, 0,            32'h0103_FFFF, 0);
    addv(3, 0, 1, 0,            0,             0);
    addv(3, 1, 0, 0,            32'h0103_FFFF, 0);
    addv(3, 1, 1, 0,            0,             0);
    addv(3, 1, 0, 32'h0100_0004, 0,            0);
    addv(3, 1, 1, 0,            32'h0100_0004, 0);
    addv(2, 1, 0, 32'h0000_00FF, 0,            0);
    addv(1, 0, 0, 32'h0000_0012, 0,            0);
    addv(1, 1, 1, 0,            32'h0000_00A5, 0);

    // reset state and register access table
    do_reset();
    check("reset readdata", readdata, 0);
    check("reset irq", 32'(irq), 0);
    foreach (vecs[i]) begin
      address = vecs[i].addr; chipselect = vecs[i].cs;
      write_n = vecs[i].wn; writedata = vecs[i].wd;
      cycle();
      check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end
    idle(1);

    // steady input accepted within 2 + 4*4 + 4 cycles at divider 4
    do_reset();
    wr(3, 32'h0100_0004);
    in_port = 8'h05;
    seen = 0;
    for (int k = 0; k < 22 && !seen; k++) begin
      rd(0, d);
      if (d == 32'h05) seen = 1;
    end
    check("t2 data settles", d, 32'h05);
    rd(2, d);
    check("t2 edge", d, 32'h05);
    wr(1, 32'h01);
    check("t2 irq same cycle as mask write", 32'(irq), 0);
    idle(1);
    check("t2 irq after mask", 32'(irq), 1);

    // short glitch rejected
    do_reset();
    wr(3, 32'h0100_0004);
    wr(1, 32'h01);
    in_port = 8'h01;
    idle(10);
    in_port = 8'h00;
    idle(30);
    rd(0, d);
    check("t3 data", d, 0);
    rd(2, d);
    check("t3 edge", d, 0);
    check("t3 irq", 32'(irq), 0);

    // W1C clear colliding with a new capture: capture wins
    do_reset();
    wr(3, 32'h0100_0000);
    wr(1, 32'h04);
    in_port = 8'h04;
    idle(10);
    in_port = 8'h00;
    idle(10);
    rd(2, d);
    check("t4 edge pending", d, 32'h04);
    in_port = 8'h04;
    idle(5);
    wr(2, 32'h04);           // lands on the accept edge
    rd(0, d);
    check("t4 data", d, 32'h04);
    rd(2, d);
    check("t4 edge after race", d, 32'h04);
    wr(2, 32'h04);
    check("t4 irq on clear edge", 32'(irq), 1);
    idle(1);
    check("t4 irq after clear", 32'(irq), 0);
    rd(2, d);
    check("t4 edge cleared", d, 0);

    // falling-only edge mode
    do_reset();
    wr(3, 32'h0101_0000);
    in_port = 8'hFF;
    idle(10);
    rd(2, d);
    check("t5 rise ignored", d, 0);
    rd(0, d);
    check("t5 data high", d, 32'hFF);
    in_port = 8'h00;
    idle(10);
    rd(2, d);
    check("t5 fall captured", d, 32'hFF);
    wr(2, 32'hFF);
    in_port = 8'hFF;
    idle(10);
    rd(2, d);
    check("t5 rise after clear", d, 0);

    // disable freezes debounce; async reset mid-debounce
    do_reset();
    wr(3, 32'h0102_0000);
    in_port = 8'hFF;
    idle(10);
    wr(2, 32'hFF);
    in_port = 8'h00;
    idle(10);
    rd(2, d);
    check("t6 both-mode fall", d, 32'hFF);
    wr(1, 32'hFF);
    idle(2);
    check("t6 irq set", 32'(irq), 1);
    wr(3, 32'h0000_0004);
    in_port = 8'hFF;
    idle(1000);
    rd(0, d);
    check("t6 data frozen", d, 0);
    wr(3, 32'h0100_0004);
    idle(8);
    rd(3, d);
    check("t6 ctrl before reset", d, 32'h0100_0004);
    check("t6 irq before reset", 32'(irq), 1);
    #2 reset_n = 0;
    model_reset();
    #1;
    check("t6 async readdata", readdata, 0);
    check("t6 async irq", 32'(irq), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    in_port = 8'h00;
    rd(3, d);
    check("t6 ctrl after reset", d, 32'h0100_C350);
    rd(0, d);
    check("t6 data after reset", d, 0);

    // randomized traffic against the reference
    do_reset();
    wr(3, 32'h0100_0001);
    for (int k = 0; k < 4000; k++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 7) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      if (address == 2'd3)
        writedata = {7'b0, 1'($urandom_range(0, 7) != 0), 6'($urandom),
                     2'($urandom), 16'($urandom_range(0, 4))};
      if ($urandom_range(0, 15) == 0)
        in_port = in_port ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0)
        in_port = 8'($urandom);
      cycle();
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
